pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Two-entry valid/ready pipeline register (skid buffer), WORDSIZE bits wide.
- It sits on the read side of a stage boundary: it takes words from an upstream producer and holds them until a downstream consumer accepts them.
- The `in_ready` output is driven straight from a flop, so ready never forms a combinational path from `out_ready` back to the producer.
- Order is strictly FIFO; no word is ever dropped or duplicated, except through a flush.

Parameters:
- WORDSIZE, 32, data width in bits; matches the project-wide `WORDSIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous discard of all held words.
- in_data  input  WORDSIZE  upstream word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept this cycle; registered.
- out_data  output  WORDSIZE  oldest held word; registered.
- out_valid  output  1  out_data is valid; registered.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  2  words held: 0, 1 or 2.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage is two registers:
  - main drives out_data.
  - skid holds a second word.
- States:
  - EMPTY: occupancy 0.
  - ONE: occupancy 1.
  - FULL: occupancy 2.
- Output decode:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both are flops or decoded directly from the state flops, never from inputs.
- Reset (clr=0, asynchronous):
  - State becomes EMPTY; main and skid become 0.
  - Resulting outputs: out_valid=0, in_ready=1, out_data=0, occupancy=0.
  - Reset applied mid-transfer discards all held words immediately.
- Transitions (flush=0):
  - EMPTY, in_fire: main<=in_data, go to ONE.
  - EMPTY, no in_fire: stay EMPTY.
  - ONE, in_fire & out_fire: main<=in_data, stay ONE.
  - ONE, in_fire & !out_fire: skid<=in_data, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY; main keeps its value.
  - ONE, neither: hold.
  - FULL, out_fire: main<=skid, go to ONE. No in_fire is possible in FULL because in_ready=0.
  - FULL, no out_fire: hold.
- Latency:
  - A word accepted at edge N is on out_data with out_valid=1 after edge N, provided no older word is held.
  - With one or two older words held, it appears after those words are consumed.
- Throughput: one word per cycle sustained while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change.
- Flush (synchronous, highest priority below reset):
  - Next state is EMPTY.
  - A word offered with in_fire in the flush cycle counts as transferred from the upstream side but is discarded.
  - An out_fire in the flush cycle completes normally from the downstream side.
  - Data registers need not clear on flush; out_valid=0 is sufficient.
- Registers reload only on the events listed above, which is equivalent to a per-register enable; no other writes occur.
- Illegal states: none reachable; a state encoding with spare codes must recover to EMPTY.

Test Plan:
- Reset, then push 0x11 and 0x22 on consecutive cycles with out_ready=0 -> after the 2nd edge occupancy=2 and in_ready=0; out_data holds 0x11 and stays stable while stalled.
- From FULL with in_valid=1 carrying 0x33, set out_ready=1 for 3 cycles -> out_data sequence is 0x11, 0x22, 0x33; no loss, no duplicate; occupancy ends at 0.
- Sustained stream 0x01..0x10 with out_ready=1 and in_valid=1 every cycle -> one word out per cycle, 1-cycle latency, occupancy stays at 1.
- Random in_valid and out_ready for 1000 cycles against a reference queue model -> output order and values match exactly; in_ready=0 only when occupancy=2.
- With occupancy=2, assert flush together with in_valid=1 carrying 0x44 -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x44 never appears at the output.
- Assert clr low mid-stream, asynchronously between clock edges -> out_valid=0, in_ready=1, out_data=0 immediately; after release, the next pushed word 0x55 appears alone.

Source files
------------

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bundle for pipe_skid_reg: upstream word in, downstream word out,
// plus the fill level. The slave modport is the buffer's view.
interface pipe_skid_reg_if #(
  parameter int unsigned WORDSIZE = 32
);
  logic [WORDSIZE-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WORDSIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          occupancy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer: main drives out_data, skid catches the word that
// arrives while main is stalled. Handshake outputs decode from state only.
module pipe_skid_reg #(
  parameter int unsigned WORDSIZE = 32
) (
  input  logic clk,
  input  logic clr,
  input  logic flush,
  pipe_skid_reg_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [WORDSIZE-1:0] main_q, skid_q, main_d;
  logic                main_en, skid_en;
  logic                in_ready, out_valid, in_fire, out_fire;

  assign out_valid = (state == ONE) || (state == FULL);
  assign in_ready  = (state != FULL);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    main_d    = bus.in_data;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d    = skid_q;
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops everything; data registers are left as-is since out_valid masks them.
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (main_en) main_q <= main_d;
      if (skid_en) skid_q <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;

  always_comb begin
    case (state)
      ONE:     bus.occupancy = 2'd1;
      FULL:    bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg against hand-computed values
// and a reference queue.
module tb_pipe_skid_reg;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic flush = 1'b0;
  int errors = 0;
  int checks = 0;

  pipe_skid_reg_if #(.WORDSIZE(32)) bus ();

  pipe_skid_reg #(.WORDSIZE(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] data, input logic [1:0] occ);
    chk({tag, "_occ"}, 32'(bus.occupancy), 32'(occ));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(occ != 2'd0));
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'(occ != 2'd2));
    if (occ != 2'd0) chk({tag, "_data"}, bus.out_data, data);
  endtask

  logic [31:0] q[$];
  logic        iv, ordy, in_f, out_f;

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    chk_state("reset", 32'h0, 2'd0);
    chk("reset_data", bus.out_data, 32'h0);
    #9 clr = 1'b1;
    step();

    // fill to FULL with the consumer stalled
    bus.in_valid = 1'b1; bus.in_data = 32'h11;
    step(); chk_state("push11", 32'h11, 2'd1);
    bus.in_data = 32'h22;
    step(); chk_state("push22", 32'h11, 2'd2);
    bus.in_data = 32'h33;
    step(); chk_state("stall", 32'h11, 2'd2);

    // drain 11,22 while 33 slips in once a slot opens
    bus.out_ready = 1'b1;
    chk("drain0_data", bus.out_data, 32'h11);
    step(); chk_state("drain1", 32'h22, 2'd1);
    step(); chk_state("drain2", 32'h33, 2'd1);
    bus.in_valid = 1'b0;
    step(); chk_state("drain3", 32'h0, 2'd0);

    // sustained stream, one word per cycle
    for (int unsigned i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'(i);
      step(); chk_state("stream", 32'(i), 2'd1);
    end
    bus.in_valid = 1'b0;
    step(); chk_state("stream_end", 32'h0, 2'd0);

    // flush from FULL with a word offered
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'hAA;
    step();
    bus.in_data = 32'hBB;
    step(); chk_state("pre_flush", 32'hAA, 2'd2);
    flush = 1'b1; bus.in_data = 32'h44;
    step(); flush = 1'b0; bus.in_valid = 1'b0;
    chk_state("flush_full", 32'h0, 2'd0);

    // flush from ONE where the offered word is accepted then discarded
    bus.in_valid = 1'b1; bus.in_data = 32'hCC;
    step(); chk_state("pre_flush1", 32'hCC, 2'd1);
    flush = 1'b1; bus.in_data = 32'h44;
    step(); flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk_state("flush_one", 32'h0, 2'd0);
    step(); chk_state("flush_idle", 32'h0, 2'd0);
    bus.in_valid = 1'b1; bus.in_data = 32'h66;
    step(); chk_state("post_flush", 32'h66, 2'd1);
    bus.in_valid = 1'b0;
    step(); chk_state("post_flush_drain", 32'h0, 2'd0);

    // random traffic against a reference queue
    for (int unsigned n = 0; n < 1000; n++) begin
      chk_state("rand", (q.size() != 0) ? q[0] : 32'h0, 2'(q.size()));
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      bus.in_data   = $urandom;
      in_f  = iv && (q.size() < 2);
      out_f = ordy && (q.size() != 0);
      step();
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(bus.in_data);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step();
    chk_state("rand_drain", 32'h0, 2'd0);

    // asynchronous reset between edges while FULL
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h77;
    step();
    bus.in_data = 32'h88;
    step(); chk_state("pre_clr", 32'h77, 2'd2);
    bus.in_valid = 1'b0;
    #2 clr = 1'b0;
    #1;
    chk_state("async_clr", 32'h0, 2'd0);
    chk("async_clr_data", bus.out_data, 32'h0);
    #2 clr = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'h55;
    step(); chk_state("after_clr", 32'h55, 2'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step(); chk_state("after_clr_drain", 32'h0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
